// File: rtl/text_stream_reader_pkg.sv
// text_stream_reader_pkg: shared constants and FSM state encoding for the text stream reader.
//   CHAR_W    - width of one character taken from memory data bits [6:0]
//   MEM_WORDS - number of valid text memory locations (0..MEM_WORDS-1)
//   state_t   - FSM state type; IDLE/RUN/DRAIN/DONE/ERR encodings
package text_stream_pkg;
    localparam int unsigned CHAR_W    = 7;
    localparam int unsigned MEM_WORDS = 60349;
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t RUN   = 3'd1;
    localparam state_t DRAIN = 3'd2;
    localparam state_t DONE  = 3'd3;
    localparam state_t ERR   = 3'd4;
endpackage

// File: rtl/text_stream_reader_if.sv
// text_stream_reader_if: memory read port plus character stream between reader and its environment.
//   master: reader side (drives MemoryAddress/memRD/memWD/DataIn and the char stream)
//   slave : memory/consumer side (drives DataOut and char_ready)
interface text_stream_reader_if
    import text_stream_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] MemoryAddress;
    logic              memRD;
    logic              memWD;
    logic [ADDR_W-1:0] DataIn;
    logic [ADDR_W-1:0] DataOut;
    logic [CHAR_W-1:0] char_data;
    logic              char_valid;
    logic              char_ready;
    logic              char_last;
    modport master (
        output MemoryAddress, memRD, memWD, DataIn, char_data, char_valid, char_last,
        input  DataOut, char_ready
    );
    modport slave (
        input  MemoryAddress, memRD, memWD, DataIn, char_data, char_valid, char_last,
        output DataOut, char_ready
    );
endinterface

// File: rtl/text_stream_reader_char_fifo.sv
// char_fifo: synchronous character FIFO with occupancy count.
//   clk, rst_n       - clock, asynchronous active-low reset
//   push_i, data_i   - write strobe and character
//   pop_i, data_o    - read strobe and head character (0 while empty)
//   count_o          - occupancy 0..DEPTH
//   empty_o, full_o  - status flags
module char_fifo
    import text_stream_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [CHAR_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [CHAR_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i) rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end
    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign count_o = count_q;
    // Storage is not reset, so the head is masked to keep the output clean while empty.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
endmodule

// File: rtl/text_stream_reader.sv
// text_stream_reader: walks a memory address range and streams the 7-bit characters read back.
//   clk, Reset                 - clock, asynchronous active-low reset
//   start, base_addr, length   - command (sampled in IDLE only)
//   busy, done, err            - command status (done/err are one-cycle pulses)
//   bus (master)               - registered memory read port and valid/ready character stream
module text_stream_reader #(
    parameter int          ADDR_W    = 32,
    parameter int          LEN_W     = 16,
    parameter int          DEPTH     = 4,
    parameter int unsigned MEM_WORDS = text_stream_pkg::MEM_WORDS
)(
    input  logic               clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LEN_W-1:0]   length,
    output logic               busy,
    output logic               done,
    output logic               err,
    text_stream_reader_if.master bus
);
    import text_stream_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [LEN_W-1:0]  issue_left_q, issue_left_d, pop_left_q, pop_left_d;
    logic              rd_q, rd_d, rd_v_q;
    logic [CW-1:0]     count;
    logic              empty, full, pop, credit, range_ok;
    logic [ADDR_W:0]   end_addr;
    logic              unused_bits;
    assign unused_bits = ^{bus.DataOut[ADDR_W-1:CHAR_W], full};
    assign pop      = bus.char_valid & bus.char_ready;
    assign end_addr = {1'b0, base_addr} + (ADDR_W+1)'(length);
    assign range_ok = end_addr <= (ADDR_W+1)'(MEM_WORDS);
    // A read may issue only if, after this edge's push/pop, every in-flight read
    // (rd_q: on the bus now, rd_v_q: data arriving now) still has a FIFO slot.
    assign credit = ({1'b0, count} + (CW+1)'(rd_q) + (CW+1)'(rd_v_q)) < ((CW+1)'(DEPTH) + (CW+1)'(pop));
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q - LEN_W'(pop);
        rd_d         = 1'b0;
        if (state_q == IDLE && start) begin
            if (length == '0) begin
                state_d = DONE;
            end else if (!range_ok) begin
                state_d = ERR;
            end else begin
                // First read goes out straight from the accepting edge; FIFO is empty in IDLE.
                state_d      = RUN;
                rd_d         = 1'b1;
                addr_d       = base_addr;
                ptr_d        = base_addr + ADDR_W'(1);
                issue_left_d = length - LEN_W'(1);
                pop_left_d   = length;
            end
        end else if (state_q == RUN) begin
            if (issue_left_q != '0 && credit) begin
                rd_d         = 1'b1;
                addr_d       = ptr_q;
                ptr_d        = ptr_q + ADDR_W'(1);
                issue_left_d = issue_left_q - LEN_W'(1);
            end
            if (issue_left_d == '0) state_d = DRAIN;
        end else if (state_q == DRAIN) begin
            if (pop && pop_left_q == LEN_W'(1)) state_d = DONE;
        end else if (state_q == DONE || state_q == ERR) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            addr_q       <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            rd_q         <= 1'b0;
            rd_v_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            rd_q         <= rd_d;
            rd_v_q       <= rd_q;
        end
    end
    char_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (Reset),
        .push_i  (rd_v_q),
        .data_i  (bus.DataOut[CHAR_W-1:0]),
        .pop_i   (pop),
        .data_o  (bus.char_data),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );
    assign bus.MemoryAddress = addr_q;
    assign bus.memRD         = rd_q;
    assign bus.memWD         = 1'b0;
    assign bus.DataIn        = '0;
    assign bus.char_valid    = !empty;
    assign bus.char_last     = !empty && pop_left_q == LEN_W'(1);
    assign busy              = state_q == RUN || state_q == DRAIN;
    assign done              = state_q == DONE;
    assign err               = state_q == ERR;
endmodule

// File: doc/text_stream_reader.md
# text_stream_reader

Initiator-side block for the processor's text data memory. On a start command it walks a contiguous address range, drives the memory read port, captures the 7-bit character returned one cycle later, and presents the characters as a valid/ready stream to downstream logic (display/UART formatter). It never writes memory. Reads are credit-limited by an internal FIFO, so downstream backpressure never loses a character.

## Interface
- `ADDR_W`, 32, width of memory address and data buses
- `LEN_W`, 16, width of the length field
- `DEPTH`, 4, character FIFO depth (power of two, ≥3 for full throughput)
- `MEM_WORDS`, 60349, number of valid memory locations (0..MEM_WORDS-1)

- `clk`  in  1  single clock, all state on rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe, sampled only in IDLE
- `base_addr`  in  ADDR_W  first address, sampled with start
- `length`  in  LEN_W  character count, sampled with start
- `busy`  out  1  high from the cycle after an accepted start until done/err
- `done`  out  1  one-cycle pulse after the last character handshake
- `err`  out  1  one-cycle pulse on rejected command
- `MemoryAddress`  out  ADDR_W  read address, registered
- `memRD`  out  1  read strobe, registered
- `memWD`  out  1  tied 0
- `DataIn`  out  ADDR_W  tied 0
- `DataOut`  in  ADDR_W  memory read data; bits [6:0] used, [31:7] ignored
- `char_data`  out  7  FIFO head
- `char_valid`  out  1  FIFO non-empty
- `char_ready`  in  1  consumer accept
- `char_last`  out  1  high with the final character of the command

## Operation
- States: IDLE, RUN, DRAIN, DONE, ERR.
- IDLE + start: length==0 → DONE; base_addr+length > MEM_WORDS (computed at ADDR_W+1 bits, no wrap) → ERR; else load issue pointer=base_addr, issue_left=length, pop_left=length → RUN. start in any other state ignored.
- RUN: next-cycle memRD=1 with MemoryAddress=issue pointer when issue_left>0 and fifo_count+outstanding < DEPTH; outstanding = reads issued not yet pushed (0..2). Pointer increments, issue_left decrements per issued read. When issue_left reaches 0 → DRAIN.
- Capture: every cycle following a memRD=1 cycle, DataOut[6:0] pushed into FIFO. DataOut is never sampled in any other cycle (memory echoes address when idle).
- Stream: char_valid = FIFO non-empty; handshake on char_valid&char_ready pops and decrements pop_left; char_last = char_valid & (pop_left==1).
- DRAIN: when pop_left reaches 0 → DONE.
- DONE: done=1 for one cycle → IDLE. ERR: err=1 for one cycle → IDLE. busy=1 in RUN and DRAIN only.
- Simultaneous push and pop on a full FIFO is legal (count unchanged); credit rule guarantees push never hits a full FIFO without a pop.

## Timing
- Reset (async assert, sync release): state IDLE, memRD=0, MemoryAddress=0, memWD=0, DataIn=0, busy=0, done=0, err=0, FIFO empty (char_valid=0, char_last=0, char_data=0). Reset mid-command aborts it; in-flight memory data is discarded.
- start sampled at edge E0 → memRD high in cycle 1 with base_addr → data pushed at end of cycle 2 → char_valid in cycle 3.
- With char_ready held high: one memRD per cycle, one character per cycle, done in cycle length+3.
- char_ready low: memRD stops once fifo_count+outstanding reaches DEPTH; resumes the cycle after a pop frees credit.
- char_data/char_last stable while char_valid & !char_ready.

## Structure
- Shared package `text_stream_pkg`: state enum (IDLE, RUN, DRAIN, DONE, ERR), `MEM_WORDS`, char width constant 7.
- One sub-module: `char_fifo` (synchronous FIFO, parameter DEPTH, 7-bit data, push/pop/count/empty/full). Counters and FSM in top level.

## Test plan
- base 0, length 5, char_ready=1, memory "HELLO" → memRD cycles 1–5 addr 0–4; chars H,E,L,L,O cycles 3–7; char_last with O; done cycle 8.
- length 0 → no memRD, done pulse next cycle, busy stays 0.
- base 60345, length 5 → err pulse next cycle, no memRD; base 60344, length 5 accepted, last addr 60348.
- length 10, char_ready low 6 cycles then high → exactly DEPTH reads issued during stall, no lost/duplicated chars, order preserved.
- start pulsed during RUN → ignored; Reset low mid-RUN → all outputs at reset values immediately, new command afterwards runs cleanly.
